cpp_double_to_int_convert_pipe: RTL and testbench



---
 rtl/cpp_fp_pkg.sv | 32 +++
 rtl/cpp_fp64_unpack.sv | 31 +++
 rtl/cpp_double_to_int_convert_pipe.sv | 178 +++++++++++++++++
 tb/tb_cpp_double_to_int_convert_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpp_fp_pkg.sv
// Shared binary64 field layout, rounding-mode encodings and the operand class
// used by the double-to-integer conversion pipeline.
package cpp_fp_pkg;

    localparam int EXP_W    = 11;
    localparam int FRAC_W   = 52;
    localparam int SIG_W    = FRAC_W + 1;
    localparam int EXP_BIAS = 1023;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam logic [1:0] MODE_TRUNC = 2'd0;
    localparam logic [1:0] MODE_RNE   = 2'd1;
    localparam logic [1:0] MODE_FLOOR = 2'd2;
    localparam logic [1:0] MODE_CEIL  = 2'd3;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        FINITE = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    // exp is the unbiased exponent; zero/subnormal inputs carry -1022
    typedef struct packed {
        logic                sign;
        logic signed [12:0]  exp;
        logic [SIG_W-1:0]    sig;
        fp_class_e           cls;
    } fp_unpacked_t;

endpackage

// File: rtl/cpp_fp64_unpack.sv
// Combinational binary64 unpack: splits sign/exponent/significand and
// classifies the operand as zero, finite, infinity or NaN.
module cpp_fp64_unpack
    import cpp_fp_pkg::*;
(
    input  logic [63:0]  i_bits,
    output fp_unpacked_t o_fp
);

    logic [EXP_W-1:0]  w_exp_field;
    logic [FRAC_W-1:0] w_frac;

    assign w_exp_field = i_bits[62:52];
    assign w_frac      = i_bits[51:0];

    always_comb begin
        o_fp.sign = i_bits[63];
        o_fp.sig  = {1'b1, w_frac};
        o_fp.exp  = $signed({2'b00, w_exp_field}) - $signed(13'(EXP_BIAS));
        o_fp.cls  = FINITE;
        if (w_exp_field == '0) begin
            // Subnormals keep no hidden bit; their value stays far below 0.5
            o_fp.sig = {1'b0, w_frac};
            o_fp.exp = 13'sd1 - $signed(13'(EXP_BIAS));
            o_fp.cls = (w_frac == '0) ? ZERO : FINITE;
        end else if (w_exp_field == EXP_MAX) begin
            o_fp.cls = (w_frac == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/cpp_double_to_int_convert_pipe.sv
// Two-stage binary64 -> signed OUT_W integer converter with selectable rounding,
// saturation or wrap on overflow, and valid/ready flow control on both sides.
module cpp_double_to_int_convert_pipe
    import cpp_fp_pkg::*;
#(
    parameter int OUT_W    = 32,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [63:0]             in,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ovf,
    output logic                    inv,
    output logic                    inexact
);

    // Handshake: a beat moves on either side only when valid && ready at the
    // rising edge; out/flags are held unchanged while out_valid && !out_ready.

    localparam int MW = OUT_W + 2;
    localparam logic signed [12:0] OUT_W_S = 13'(OUT_W);
    localparam logic [MW-1:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    fp_unpacked_t w_unp;
    logic         w_s2_adv;
    logic         w_in_ready;

    logic         r_s1_valid;
    fp_unpacked_t r_s1_fp;
    logic [1:0]   r_s1_mode;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out;
    logic             r_ovf;
    logic             r_inv;
    logic             r_inexact;

    cpp_fp64_unpack u_unpack (
        .i_bits (in),
        .o_fp   (w_unp)
    );

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign in_ready   = w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_fp    <= '0;
            r_s1_mode  <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fp   <= w_unp;
                r_s1_mode <= mode;
            end
        end
    end

    logic signed [12:0] w_e;
    logic [12:0]        w_rsh;
    logic [12:0]        w_lsh;
    logic [106:0]       w_rx;
    logic [MW-1:0]      w_int;
    logic [MW-1:0]      w_rnd;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic               w_big;
    logic               w_range_ovf;
    logic [OUT_W-1:0]   w_res;
    logic               w_ovf;
    logic               w_inv;
    logic               w_inexact;

    assign w_e   = r_s1_fp.exp;
    assign w_rsh = 13'sd52 - w_e;
    assign w_lsh = w_e - 13'sd52;

    // Integer part, guard bit and sticky bit of |value|
    always_comb begin
        w_rx     = '0;
        w_int    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        if (r_s1_fp.cls == FINITE) begin
            if (w_e <= 13'sd52) begin
                if (w_rsh > 13'd54) begin
                    w_sticky = |r_s1_fp.sig;
                end else begin
                    w_rx     = {r_s1_fp.sig, 54'b0} >> w_rsh;
                    w_int    = MW'(w_rx >> 54);
                    w_guard  = w_rx[53];
                    w_sticky = |w_rx[52:0];
                end
            end else begin
                // Only the low MW bits matter; anything higher is caught by w_big
                w_int = MW'({{MW{1'b0}}, r_s1_fp.sig} << w_lsh);
            end
        end
    end

    always_comb begin
        w_inc = 1'b0;
        unique case (r_s1_mode)
            MODE_TRUNC: w_inc = 1'b0;
            MODE_RNE:   w_inc = w_guard && (w_sticky || w_int[0]);
            MODE_FLOOR: w_inc = (w_guard || w_sticky) && r_s1_fp.sign;
            default:    w_inc = (w_guard || w_sticky) && !r_s1_fp.sign;
        endcase
    end

    assign w_rnd       = w_int + MW'(w_inc);
    assign w_big       = (w_e >= OUT_W_S);
    assign w_range_ovf = w_big || (r_s1_fp.sign ? (w_rnd > NEG_LIM) : (w_rnd > POS_LIM));

    always_comb begin
        w_res     = OUT_W'(r_s1_fp.sign ? -w_rnd : w_rnd);
        w_ovf     = 1'b0;
        w_inv     = 1'b0;
        w_inexact = 1'b0;
        unique case (r_s1_fp.cls)
            NAN: begin
                w_res = '0;
                w_inv = 1'b1;
            end
            INF: begin
                w_ovf = 1'b1;
                w_res = ((SATURATE != 0) && !r_s1_fp.sign) ? SAT_POS : SAT_NEG;
            end
            FINITE: begin
                w_inexact = w_guard || w_sticky;
                if (w_range_ovf) begin
                    w_ovf = 1'b1;
                    if (SATURATE != 0) begin
                        w_res = r_s1_fp.sign ? SAT_NEG : SAT_POS;
                    end
                end
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_inv       <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out     <= w_res;
                r_ovf     <= w_ovf;
                r_inv     <= w_inv;
                r_inexact <= w_inexact;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign inv       = r_inv;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_cpp_double_to_int_convert_pipe.sv
// Bench for cpp_double_to_int_convert_pipe (OUT_W=32, SATURATE=1): directed
// corner values, randomised streams under random backpressure, reset flush.
module tb_cpp_double_to_int_convert_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] din;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        inv;
  logic        inexact;

  // entries are {ovf, inv, inexact, out[31:0]}
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_mode = 0;

  cpp_double_to_int_convert_pipe #(
    .OUT_W    (32),
    .SATURATE (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .inv       (inv),
    .inexact   (inexact)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // independent real-arithmetic reference
  function automatic void model(input logic [63:0] x, input logic [1:0] m,
                                output logic [31:0] r, output logic [2:0] f);
    real    v;
    real    fl;
    real    rr;
    longint li;
    r = '0;
    f = '0;
    if (x[62:52] == 11'h7FF) begin
      if (x[51:0] != 52'd0) begin
        f = 3'b010;
      end else begin
        f = 3'b100;
        r = x[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return;
    end
    v  = $bitstoreal(x);
    fl = $floor(v);
    case (m)
      2'd0: rr = (v < 0.0) ? $ceil(v) : fl;
      2'd1: begin
        if (v - fl > 0.5) rr = fl + 1.0;
        else if (v - fl < 0.5) rr = fl;
        else begin
          li = longint'(fl);
          rr = li[0] ? fl + 1.0 : fl;
        end
      end
      2'd2: rr = fl;
      default: rr = $ceil(v);
    endcase
    f[0] = (v != fl);
    if (rr > 2147483647.0) begin
      f[2] = 1'b1;
      r = 32'h7FFF_FFFF;
    end else if (rr < -2147483648.0) begin
      f[2] = 1'b1;
      r = 32'h8000_0000;
    end else begin
      li = longint'(rr);
      r = li[31:0];
    end
  endfunction

  function automatic logic [63:0] rand_double();
    real    v;
    longint ip;
    case ($urandom_range(0, 3))
      0: ip = longint'($urandom_range(0, 20));
      1: ip = 64'd2147483640 + longint'($urandom_range(0, 16));
      2: ip = longint'($urandom) * 256;
      default: ip = 0;
    endcase
    v = real'(ip) + real'($urandom_range(0, 7)) / 8.0;
    if ($urandom_range(0, 1) == 1) v = -v;
    return $realtobits(v);
  endfunction

  // driver tasks
  task automatic send(input logic [63:0] x, input logic [1:0] m,
                      input logic [31:0] eo, input logic [2:0] ef);
    bit acc;
    int n;
    din      = x;
    mode     = m;
    in_valid = 1'b1;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back({ef, eo});
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send_model(input logic [63:0] x, input logic [1:0] m);
    logic [31:0] eo;
    logic [2:0]  ef;
    model(x, m, eo, ef);
    send(x, m, eo, ef);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard: front entry must be on out whenever out_valid, popped on accept
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("stale_out", 64'(out_valid), 64'd0);
      end else begin
        mon_e = exp_q[0];
        check("out", 64'(dout), 64'(mon_e[31:0]));
        check("flags", 64'({ovf, inv, inexact}), 64'(mon_e[34:32]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] b;
    reset    = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    mode     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out", 64'(dout), 64'd0);
    check("rst_flags", 64'({ovf, inv, inexact}), 64'd0);
    @(posedge clk);
    #1;

    // two-cycle latency
    send(64'h400C000000000000, 2'd0, 32'd3, 3'b001);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat2_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // directed corner values
    send(64'h400C000000000000, 2'd1, 32'd4, 3'b001);
    send(64'h400C000000000000, 2'd2, 32'd3, 3'b001);
    send(64'h400C000000000000, 2'd3, 32'd4, 3'b001);
    send(64'hC004000000000000, 2'd0, 32'hFFFF_FFFE, 3'b001);
    send(64'hC004000000000000, 2'd1, 32'hFFFF_FFFE, 3'b001);
    send(64'hC004000000000000, 2'd2, 32'hFFFF_FFFD, 3'b001);
    send(64'hC004000000000000, 2'd3, 32'hFFFF_FFFE, 3'b001);
    send(64'h4202A05F20000000, 2'd0, 32'h7FFF_FFFF, 3'b100);
    send(64'hC1E0000000000000, 2'd0, 32'h8000_0000, 3'b000);
    send(64'h7FF8000000000000, 2'd0, 32'h0000_0000, 3'b010);
    send(64'h7FF0000000000000, 2'd0, 32'h7FFF_FFFF, 3'b100);
    send(64'hFFF0000000000000, 2'd1, 32'h8000_0000, 3'b100);
    send(64'h8000000000000000, 2'd2, 32'h0000_0000, 3'b000);
    send(64'h0000000000000001, 2'd3, 32'h0000_0001, 3'b001);
    send(64'h0000000000000001, 2'd0, 32'h0000_0000, 3'b001);
    send(64'h8000000000000001, 2'd2, 32'hFFFF_FFFF, 3'b001);
    b = $realtobits(0.5);
    send(b, 2'd1, 32'd0, 3'b001);
    b = $realtobits(1.5);
    send(b, 2'd1, 32'd2, 3'b001);
    b = $realtobits(2147483647.5);
    send(b, 2'd0, 32'h7FFF_FFFF, 3'b001);
    send(b, 2'd1, 32'h7FFF_FFFF, 3'b101);
    b = $realtobits(-2147483648.5);
    send(b, 2'd0, 32'h8000_0000, 3'b001);
    send(b, 2'd2, 32'h8000_0000, 3'b101);
    drain();

    // back-to-back stream of 8 under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 8; i++) send_model(rand_double(), 2'($urandom_range(0, 3)));
    drain();

    // longer randomised stream
    for (int i = 0; i < 40; i++) begin
      send_model(rand_double(), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    drain();

    // reset with two items in flight
    ready_mode = 1;
    @(posedge clk);
    #1;
    send_model(rand_double(), 2'd0);
    send_model(rand_double(), 2'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    ready_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    send(64'h400C000000000000, 2'd3, 32'd4, 3'b001);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
